// File: rtl/sd_wr_data_gen_pkg.sv
// sd_wr_data_gen_pkg
// Definitions shared by the SD write pattern source and the read-side checker.
// Contents:
//   - per-block word and request counts
//   - one-hot FSM state encodings
//   - the pattern step function, so both sides generate the same data sequence
package sd_wr_data_gen_pkg;

  // Data words carried by one 512-byte sector.
  localparam int WORDS_PER_SEC = 256;

  // Requests the write stage issues per block; the last one is never used.
  localparam int REQ_PER_SEC = 257;

  // One-hot state encodings.
  localparam logic [7:0] ST_IDLE      = 8'b0000_0001;
  localparam logic [7:0] ST_STRB      = 8'b0000_0010;
  localparam logic [7:0] ST_WAIT_BUSY = 8'b0000_0100;
  localparam logic [7:0] ST_XFER      = 8'b0000_1000;
  localparam logic [7:0] ST_CHECK     = 8'b0001_0000;
  localparam logic [7:0] ST_GAP       = 8'b0010_0000;
  localparam logic [7:0] ST_DONE      = 8'b0100_0000;
  localparam logic [7:0] ST_ERR       = 8'b1000_0000;

  // Next pattern word: the sequence advances by a fixed step, mod 2^16.
  function automatic logic [15:0] pattern_step(input logic [15:0] cur,
                                               input logic [15:0] step);
    return cur + step;
  endfunction

endpackage

// File: rtl/sd_pattern_ctr.sv
// sd_pattern_ctr
// 16-bit pattern counter. It loads a start value, or advances by a step.
// The read-side checker reuses it to regenerate the same pattern.
// Ports:
//   clk, rst_n  clock; asynchronous active-low reset (value returns to RST_VAL)
//   load        load load_val; has priority over step_en
//   load_val    value to load
//   step_en     advance value by step
//   step        step size, mod 2^16
//   value       current pattern word
module sd_pattern_ctr
  import sd_wr_data_gen_pkg::*;
#(
  parameter logic [15:0] RST_VAL = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] load_val,
  input  logic        step_en,
  input  logic [15:0] step,
  output logic [15:0] value
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= RST_VAL;
    end else if (load) begin
      value <= load_val;
    end else if (step_en) begin
      value <= pattern_step(value, step);
    end
  end

endmodule

// File: rtl/sd_wr_data_gen.sv
// sd_wr_data_gen
// Pattern source for the SD single-block write stage. It writes a run of
// SEC_NUM sectors, starting at sector START_SEC.
// For each sector it:
//   - pulses wr_start_en for two cycles;
//   - serves one word per wr_req;
//   - waits for wr_busy to fall;
//   - checks that at least 256 words were taken.
// Ports:
//   clk_ref_180deg  inverted SD reference clock
//   rst_n           asynchronous active-low reset
//   init_done       SD card initialised (level)
//   start           run request, rising-edge sensitive
//   wr_busy         write stage busy
//   wr_req          write stage requests the next data word
//   wr_start_en     write-start strobe (2 cycles)
//   wr_sec_addr     sector address of the current write
//   wr_data         current data word
//   sec_cnt         sectors completed in this run
//   run_busy        run in progress
//   run_done        run finished OK (sticky until next accepted start)
//   run_err         run aborted (sticky until next accepted start)
//   state           current one-hot FSM state (debug)
//
// Data handshake: a wr_req seen high on a clock edge consumes the word
// presented on wr_data. The next word appears on wr_data after that same
// edge. There is no back-pressure: this block is always ready, and every
// wr_req in XFER is valid. A wr_req outside XFER is ignored.
module sd_wr_data_gen
  import sd_wr_data_gen_pkg::*;
#(
  parameter logic [31:0] START_SEC  = 32'd2000,
  parameter logic [15:0] SEC_NUM    = 16'd4,
  parameter logic [15:0] DATA_INIT  = 16'h0000,
  parameter logic [15:0] DATA_STEP  = 16'h0001,
  parameter logic [7:0]  GAP_CYCLES = 8'd16,
  parameter logic [23:0] TIMEOUT    = 24'hFF_FFFF
) (
  input  logic        clk_ref_180deg,
  input  logic        rst_n,
  input  logic        init_done,
  input  logic        start,
  input  logic        wr_busy,
  input  logic        wr_req,
  output logic        wr_start_en,
  output logic [31:0] wr_sec_addr,
  output logic [15:0] wr_data,
  output logic [15:0] sec_cnt,
  output logic        run_busy,
  output logic        run_done,
  output logic        run_err,
  output logic [7:0]  state
);

  logic        start_q;
  logic        busy_q;
  logic        strb_cnt;
  logic [23:0] tmo_cnt;
  logic [8:0]  req_cnt;
  logic [7:0]  gap_cnt;

  logic        start_acc;
  logic        data_step;
  logic        tmo_hit;
  logic        gap_last;
  logic        words_ok;
  logic [15:0] sec_next;

  assign start_acc = (state == ST_IDLE) && start && !start_q && init_done;
  assign words_ok  = (req_cnt >= 9'(WORDS_PER_SEC));
  // Only the first 256 requests of a block advance the pattern.
  // The write stage's 257th request reads a word that is thrown away.
  assign data_step = (state == ST_XFER) && wr_req && !words_ok;
  assign tmo_hit   = (tmo_cnt == TIMEOUT);
  // Count up to GAP_CYCLES. GAP_CYCLES = 0 still spends one cycle in GAP.
  assign gap_last  = ({1'b0, gap_cnt} + 9'd1) >= {1'b0, GAP_CYCLES};
  assign sec_next  = sec_cnt + 16'd1;

  // wr_data is never reset between sectors. It reloads only when a run is accepted.
  sd_pattern_ctr #(
    .RST_VAL (DATA_INIT)
  ) u_pattern (
    .clk      (clk_ref_180deg),
    .rst_n    (rst_n),
    .load     (start_acc),
    .load_val (DATA_INIT),
    .step_en  (data_step),
    .step     (DATA_STEP),
    .value    (wr_data)
  );

  always_ff @(posedge clk_ref_180deg or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      start_q     <= 1'b0;
      busy_q      <= 1'b0;
      strb_cnt    <= 1'b0;
      tmo_cnt     <= '0;
      req_cnt     <= '0;
      gap_cnt     <= '0;
      wr_start_en <= 1'b0;
      wr_sec_addr <= START_SEC;
      sec_cnt     <= '0;
      run_busy    <= 1'b0;
      run_done    <= 1'b0;
      run_err     <= 1'b0;
    end else begin
      start_q <= start;
      busy_q  <= wr_busy;
      case (state)
        ST_IDLE: begin
          if (start_acc) begin
            run_done    <= 1'b0;
            run_err     <= 1'b0;
            sec_cnt     <= '0;
            wr_sec_addr <= START_SEC;
            run_busy    <= 1'b1;
            if (SEC_NUM == 16'd0) begin
              state <= ST_DONE;
            end else begin
              state       <= ST_STRB;
              wr_start_en <= 1'b1;
              strb_cnt    <= 1'b0;
            end
          end
        end
        // Hold the strobe for two cycles so the clk_ref-domain edge detector sees it.
        ST_STRB: begin
          if (strb_cnt) begin
            wr_start_en <= 1'b0;
            tmo_cnt     <= '0;
            req_cnt     <= '0;
            state       <= ST_WAIT_BUSY;
          end else begin
            strb_cnt <= 1'b1;
          end
        end
        ST_WAIT_BUSY: begin
          if (wr_busy) begin
            tmo_cnt <= '0;
            state   <= ST_XFER;
          end else if (tmo_hit) begin
            state <= ST_ERR;
          end else begin
            tmo_cnt <= tmo_cnt + 24'd1;
          end
        end
        ST_XFER: begin
          if (wr_req && (req_cnt != 9'(REQ_PER_SEC))) begin
            req_cnt <= req_cnt + 9'd1;
          end
          if (busy_q && !wr_busy) begin
            state <= ST_CHECK;
          end else if (wr_req) begin
            tmo_cnt <= '0;
          end else if (tmo_hit) begin
            state <= ST_ERR;
          end else begin
            tmo_cnt <= tmo_cnt + 24'd1;
          end
        end
        ST_CHECK: begin
          if (!words_ok) begin
            state <= ST_ERR;
          end else begin
            sec_cnt     <= sec_next;
            wr_sec_addr <= wr_sec_addr + 32'd1;
            if (sec_next == SEC_NUM) begin
              state <= ST_DONE;
            end else if (!init_done) begin
              state <= ST_ERR;
            end else begin
              gap_cnt <= '0;
              state   <= ST_GAP;
            end
          end
        end
        ST_GAP: begin
          if (gap_last) begin
            if (!init_done) begin
              state <= ST_ERR;
            end else begin
              wr_start_en <= 1'b1;
              strb_cnt    <= 1'b0;
              state       <= ST_STRB;
            end
          end else begin
            gap_cnt <= gap_cnt + 8'd1;
          end
        end
        ST_DONE: begin
          run_done <= 1'b1;
          run_busy <= 1'b0;
          state    <= ST_IDLE;
        end
        ST_ERR: begin
          run_err     <= 1'b1;
          run_busy    <= 1'b0;
          wr_start_en <= 1'b0;
          state       <= ST_IDLE;
        end
        default: begin
          wr_start_en <= 1'b0;
          run_busy    <= 1'b0;
          state       <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
